byte_destriper: RTL

BYTE_DESTRIPER -- requirements
Module: byte_destriper

---
 rtl/byte_destriper.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/byte_destriper.sv
// byte_destriper
//   Reassembles a byte stream that was striped byte-by-byte across NUM_LANES
//   physical lanes. Each lane has its own deskew FIFO. The block first finds
//   a COM K-symbol on every lane within MAX_SKEW lane_valid cycles (ALIGN).
//   It then emits one byte per handshake, lane 0 first, taking every byte
//   from the same FIFO column (ALIGNED).
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous, active-high reset
//   lane_data   lane i symbol in bits [8i+7:8i]
//   lane_k      per-lane K-symbol flag
//   lane_valid  common strobe: one symbol on every lane this cycle
//   out_data    reassembled byte (0 whenever out_valid is low)
//   out_k       K flag for out_data
//   out_valid   out_data/out_k valid
//   out_ready   sink accepts the byte when out_valid && out_ready
//   aligned     high while in ALIGNED
//   deskew_err  one-cycle pulse on an alignment failure
//   overflow    one-cycle pulse on a lane FIFO overflow

module byte_destriper #(
  parameter int         NUM_LANES  = 4,
  parameter int         FIFO_DEPTH = 8,
  parameter int         MAX_SKEW   = 4,
  parameter logic [7:0] COM_SYM    = 8'hBC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_LANES*8-1:0] lane_data,
  input  logic [NUM_LANES-1:0]   lane_k,
  input  logic                   lane_valid,
  output logic [7:0]             out_data,
  output logic                   out_k,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   aligned,
  output logic                   deskew_err,
  output logic                   overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LIW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int SCW = $clog2(MAX_SKEW + 2);  // holds MAX_SKEW+1
  localparam logic [LIW-1:0] LAST_LANE  = LIW'(NUM_LANES - 1);
  localparam logic [SCW-1:0] SKEW_LIMIT = SCW'(MAX_SKEW);

  typedef enum logic {ST_ALIGN, ST_ALIGNED} state_t;

  state_t               state;
  logic [AW:0]          wr_ptr [NUM_LANES];
  logic [AW:0]          rd_ptr [NUM_LANES];
  logic [8:0]           mem    [NUM_LANES][FIFO_DEPTH];  // {k, data}
  logic [8:0]           head   [NUM_LANES];
  logic [NUM_LANES-1:0] got_com, com_now, is_com, head_com, lane_we, empty, full;
  logic [LIW-1:0]       lane_idx;
  logic [SCW-1:0]       skew_cnt, cnt_next;
  logic [8:0]           head_sel;
  logic                 any_got, skew_err, go_aligned, head_bad;
  logic                 accept, pop, do_ovf, do_desk;

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    is_com   = '0;
    empty    = '0;
    full     = '0;
    head_com = '0;
    lane_we  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      is_com[i]   = lane_k[i] && (lane_data[8*i +: 8] == COM_SYM);
      empty[i]    = (wr_ptr[i] == rd_ptr[i]);
      // Extra MSB distinguishes full (MSBs differ) from empty (all bits equal).
      full[i]     = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                    (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      head[i]     = mem[i][rd_ptr[i][AW-1:0]];
      head_com[i] = (head[i] == {1'b1, COM_SYM});
      // Before alignment a lane only starts storing from its own first COM.
      lane_we[i]  = lane_valid && ((state == ST_ALIGNED) || got_com[i] || is_com[i]);
    end

    // Skew counting starts on the cycle of the first COM capture.
    com_now    = got_com | (is_com & {NUM_LANES{lane_valid}});
    any_got    = |got_com;
    cnt_next   = any_got ? skew_cnt + 1'b1 : '0;
    skew_err   = (state == ST_ALIGN) && lane_valid && any_got &&
                 !(&com_now) && (cnt_next > SKEW_LIMIT);
    go_aligned = (state == ST_ALIGN) && lane_valid && (&com_now) &&
                 (cnt_next <= SKEW_LIMIT);

    // A COM on lane 0 without COM on every lane means the lanes have slipped.
    head_bad  = (state == ST_ALIGNED) && !(|empty) && head_com[0] && !(&head_com);
    out_valid = (state == ST_ALIGNED) && !(|empty) && !head_bad;

    head_sel = head[lane_idx];
    accept   = out_valid && out_ready;
    pop      = accept && (lane_idx == LAST_LANE);
    // A pop in the same cycle frees the slot, so writing when full is legal.
    do_ovf   = (|(lane_we & full)) && !pop;
    do_desk  = !do_ovf && (skew_err || head_bad);

    // Gating keeps unwritten storage from ever reaching the outputs.
    out_data = out_valid ? head_sel[7:0] : 8'h00;
    out_k    = out_valid && head_sel[8];
  end

  assign aligned = (state == ST_ALIGNED);

  // NOTE: the FIFO storage is deliberately not reset; the pointers define
  // which entries are live, and the outputs are gated with out_valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_we[i] && (!full[i] || pop))
        mem[i][wr_ptr[i][AW-1:0]] <= {lane_k[i], lane_data[8*i +: 8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ALIGN;
      got_com    <= '0;
      skew_cnt   <= '0;
      lane_idx   <= '0;
      deskew_err <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      deskew_err <= do_desk;
      overflow   <= do_ovf;
      if (do_ovf || do_desk) begin
        // Flush: the offending column is dropped and alignment restarts.
        state    <= ST_ALIGN;
        got_com  <= '0;
        skew_cnt <= '0;
        lane_idx <= '0;
        for (int i = 0; i < NUM_LANES; i++) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
        end
      end else begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (lane_we[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (pop)        rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        if (accept)
          lane_idx <= (lane_idx == LAST_LANE) ? '0 : lane_idx + 1'b1;
        if (state == ST_ALIGN) begin
          got_com <= com_now;
          if (lane_valid) skew_cnt <= cnt_next;
          if (go_aligned) state <= ST_ALIGNED;
        end
      end
    end
  end

endmodule
